unpacker: RTL

- Read-path counterpart of the byte-to-word packer: pops WORD_WIDTH-bit words from the word FIFO (DDR read data) and serialises them into DATA_WIDTH-bit bytes.
- Pushes the bytes into the byte FIFO that feeds the UART transmitter.
- Byte order is the inverse of the packer: least-significant byte is emitted first, so a packed word round-trips to the original byte stream.

---
 rtl/unpacker.sv | 111 +++++++++++
 1 files changed

// File: rtl/unpacker.sv
// Word-to-byte unpacker: pops wide words from a standard (non-FWFT) word FIFO
// and pushes them, least-significant byte first, into a byte FIFO.
module unpacker #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 256,
  localparam int BYTES_PER_WORD = WORD_WIDTH / DATA_WIDTH,
  localparam int CNT_W = $clog2(BYTES_PER_WORD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_fifo_empty,
  output logic                  word_read_enable,
  input  logic                  byte_fifo_full,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  byte_write_enable,
  output logic [CNT_W-1:0]      byte_index,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  bwe_q, bwe_d;
  logic                  rd_s;

  // State, shift register and registered byte-FIFO outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= {WORD_WIDTH{1'b0}};
      idx_q   <= {CNT_W{1'b0}};
      data_q  <= {DATA_WIDTH{1'b0}};
      bwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      bwe_q   <= bwe_d;
    end
  end

  // Next-state logic and word-FIFO pop strobe.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    data_d  = data_q;
    bwe_d   = 1'b0;
    rd_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!word_fifo_empty) begin
          rd_s    = 1'b1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Non-FWFT FIFO: popped word is valid on word_in now.
        shreg_d = word_in;
        idx_d   = {CNT_W{1'b0}};
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!byte_fifo_full) begin
          data_d  = shreg_q[DATA_WIDTH-1:0];
          bwe_d   = 1'b1;
          shreg_d = shreg_q >> DATA_WIDTH;
          idx_d   = idx_q + CNT_W'(1);
          if (idx_q == LAST_IDX) begin
            // Prefetch the next word while emitting the last byte.
            if (!word_fifo_empty) begin
              rd_s    = 1'b1;
              state_d = ST_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          // Byte FIFO full: hold everything, retry next cycle.
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pop is gated by reset so nothing is consumed while held in reset.
  assign word_read_enable  = rd_s & ~rst;
  assign data_out          = data_q;
  assign byte_write_enable = bwe_q;
  assign byte_index        = idx_q;
  assign busy              = (state_q != ST_IDLE);

endmodule
